mio_bus_responder: RTL
======================

Name: mio_bus_responder

Overview:
- Responder end of the CPU memory/IO handshake. The multicycle CPU controller holds mem_r or mem_w (with cpu_mio) asserted until it samples mio_ready high on a rising edge.
- This block decodes the address, runs the access against a synchronous block RAM or a small set of internal IO registers, and returns read data together with a one-cycle mio_ready pulse.
- It sits between the CPU datapath and the RAM/LED/switch hardware.

Parameters:
- RAM_AW, 10, RAM word-address width (RAM depth 2^RAM_AW words).
- RAM_LAT, 2, cycles from accept edge to RESP entry for RAM accesses; legal range 2..15.
- IO_LAT, 1, the same for IO and unmapped accesses; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- mem_r  in  1  CPU read request, level, held until ready.
- mem_w  in  1  CPU write request, level, held until ready.
- cpu_mio  in  1  CPU bus-ownership qualifier; requests are ignored when 0.
- addr  in  32  byte address; bits [1:0] are ignored.
- data_out  in  32  CPU write data.
- data_in  out  32  read data to CPU, registered.
- mio_ready  out  1  completion pulse, registered.
- bus_err  out  1  pulses with mio_ready when the access was unmapped or illegal.
- ram_addr  out  RAM_AW  RAM word address, registered.
- ram_din  out  32  RAM write data, registered.
- ram_we  out  1  RAM write strobe, one cycle.
- ram_dout  in  32  RAM read data, valid one cycle after the address edge.
- sw_in  in  16  switch inputs.
- led_out  out  32  LED register.
- state_out  out  2  current FSM state, for debug.

Behaviour:
- Reset (asynchronous; also taken mid-access):
  - state=IDLE; mio_ready, bus_err, ram_we = 0.
  - data_in, ram_addr, ram_din, led_out = 0.
  - Any in-flight access is abandoned; no LED update and no further ram_we.
- Address map by addr[31:28]:
  - 0x0: RAM, word index addr[RAM_AW+1:2].
  - 0xE: LED register, read/write.
  - 0xF: switches, read as {16'h0, sw_in}; writes are ignored.
  - All other values: unmapped; reads return 0, writes are dropped, bus_err=1.
- Request = cpu_mio & (mem_r | mem_w). mem_r & mem_w both high is illegal: treat as a write and set bus_err.
- IDLE (state_out=0):
  - No request: stay in IDLE.
  - Request on a rising edge:
    - Latch addr, data_out, direction and region.
    - Load cnt = LAT-1, where LAT = RAM_LAT for RAM and IO_LAT otherwise.
    - Go to ACCESS.
  - For RAM on the same edge: ram_addr ← index, ram_din ← data_out, ram_we ← mem_w.
- ACCESS (state_out=1):
  - ram_we is forced to 0 after the first ACCESS cycle, so exactly one write strobe per RAM write.
  - If cnt≠0: decrement cnt and stay.
  - If cnt=0, go to RESP and on that edge:
    - RAM read: data_in ← ram_dout.
    - LED read: data_in ← led_out.
    - Switch read: data_in ← {16'h0, sw_in}.
    - LED write: led_out ← latched data.
    - Unmapped read: data_in ← 0.
    - Set mio_ready=1, and bus_err as classified.
- RESP (state_out=2):
  - mio_ready=1 for exactly this one cycle; data_in is stable.
  - Next edge: mio_ready=0, bus_err=0, go to IDLE unconditionally.
  - data_in holds its value until the next read completes.
- Back-to-back: the CPU may keep or re-assert a request in the cycle after RESP. IDLE samples it as a new access, so there are no merged or dropped transactions.
- Latency: ready is high in cycle LAT+1 after the accept edge. The CPU samples it on edge LAT+1+1; the RAM default gives 3 cycles accept→ready.
- Request withdrawn during ACCESS/RESP (protocol violation): the access still completes; mio_ready still pulses.
- cpu_mio=0 with mem_r/mem_w high: no access, block stays in IDLE.
- state value 3 is unused; it recovers to IDLE on the next edge with outputs as at reset except led_out, which is kept.

Test Plan:
- Reset, then mem_r=1, cpu_mio=1, addr=0x0000_0010, RAM word 4=0xDEADBEEF -> ram_addr=4 after accept; mio_ready high exactly 1 cycle, 3 cycles after accept; data_in=0xDEADBEEF; bus_err=0.
- mem_w=1, addr=0x0000_0008, data_out=0x12345678 -> ram_we high for exactly 1 cycle with ram_addr=2, ram_din=0x12345678; then a read of the same address returns 0x12345678.
- Write 0xA5A5_0F0F to 0xE000_0000, then read it back -> led_out=0xA5A50F0F from the RESP-entry edge; data_in=0xA5A50F0F; read of 0xF000_0000 with sw_in=0x8001 -> data_in=0x00008001; each IO access has ready 2 cycles after accept.
- Read 0x4000_0000 -> data_in=0, bus_err=1 with ready; mem_r=mem_w=1 at 0x0 -> single ram_we, bus_err=1; write to 0xF000_0000 -> LED unchanged, no ram_we.
- Emulate the CPU's IF→LW→IF pattern: request re-asserted the cycle after RESP -> two distinct ready pulses, each with correct data, no dropped access; cpu_mio=0 with mem_r=1 -> no ready for 20 cycles.
- Assert reset during ACCESS of an LED write -> mio_ready never pulses, led_out=0, state_out=0; the next request completes normally.

Source files
------------

// File: rtl/mio_bus_responder.sv
// Responder end of the CPU memory/IO handshake.
// Decodes a held mem_r/mem_w request, runs it against a synchronous block RAM
// or the internal LED/switch registers, and answers with a one-cycle
// mio_ready pulse. Read data is registered and held until the next read
// completes.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   mem_r, mem_w        CPU read/write request levels, held until ready
//   cpu_mio             bus-ownership qualifier; requests ignored when 0
//   addr, data_out      CPU byte address and write data
//   data_in             registered read data to the CPU
//   mio_ready, bus_err  completion pulse and its error flag
//   ram_addr, ram_din   registered RAM word address and write data
//   ram_we              one-cycle RAM write strobe
//   ram_dout            RAM read data, valid one cycle after the address edge
//   sw_in, led_out      switch inputs and LED register
//   state_out           current FSM state for debug
module mio_bus_responder #(
  parameter int unsigned RAM_AW  = 10,
  parameter int unsigned RAM_LAT = 2,
  parameter int unsigned IO_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic              cpu_mio,
  input  logic [31:0]       addr,
  input  logic [31:0]       data_out,
  output logic [31:0]       data_in,
  output logic              mio_ready,
  output logic              bus_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [31:0]       led_out,
  output logic [1:0]        state_out
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2,
    StBad    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RegRam,
    RegLed,
    RegSw,
    RegNone
  } region_e;

  localparam logic [3:0] RamCnt = 4'(RAM_LAT - 1);
  localparam logic [3:0] IoCnt  = 4'(IO_LAT - 1);

  state_e              r_state, w_state_d;
  region_e             r_region, w_region_d, w_region_in;
  logic [3:0]          r_cnt, w_cnt_d;
  logic                r_write, w_write_d;
  logic                r_err, w_err_d;
  logic [31:0]         r_wdata, w_wdata_d;
  logic [31:0]         r_data_in, w_data_in_d;
  logic                r_ready, w_ready_d;
  logic                r_bus_err, w_bus_err_d;
  logic [RAM_AW-1:0]   r_ram_addr, w_ram_addr_d;
  logic [31:0]         r_ram_din, w_ram_din_d;
  logic                r_ram_we, w_ram_we_d;
  logic [31:0]         r_led, w_led_d;
  logic                w_req;
  logic                w_unused;

  assign w_req    = cpu_mio & (mem_r | mem_w);
  // Only the region nibble and the RAM word index are decoded.
  assign w_unused = ^{addr[27:RAM_AW+2], addr[1:0]};

  always_comb begin
    case (addr[31:28])
      4'h0:    w_region_in = RegRam;
      4'hE:    w_region_in = RegLed;
      4'hF:    w_region_in = RegSw;
      default: w_region_in = RegNone;
    endcase
  end

  always_comb begin
    w_state_d    = r_state;
    w_region_d   = r_region;
    w_cnt_d      = r_cnt;
    w_write_d    = r_write;
    w_err_d      = r_err;
    w_wdata_d    = r_wdata;
    w_data_in_d  = r_data_in;
    w_ram_addr_d = r_ram_addr;
    w_ram_din_d  = r_ram_din;
    w_led_d      = r_led;
    w_ready_d    = 1'b0;
    w_bus_err_d  = 1'b0;
    w_ram_we_d   = 1'b0;  // strobe lives only in the first ACCESS cycle

    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          w_state_d  = StAccess;
          w_region_d = w_region_in;
          // mem_r & mem_w together is illegal and completes as a write.
          w_write_d  = mem_w;
          w_err_d    = (mem_r & mem_w) | (w_region_in == RegNone);
          w_wdata_d  = data_out;
          w_cnt_d    = (w_region_in == RegRam) ? RamCnt : IoCnt;
          if (w_region_in == RegRam) begin
            w_ram_addr_d = addr[RAM_AW+1:2];
            w_ram_din_d  = data_out;
            w_ram_we_d   = mem_w;
          end
        end
      end
      StAccess: begin
        if (r_cnt != 4'd0) begin
          w_cnt_d = r_cnt - 4'd1;
        end else begin
          w_state_d   = StResp;
          w_ready_d   = 1'b1;
          w_bus_err_d = r_err;
          unique case (r_region)
            RegRam:  if (!r_write) w_data_in_d = ram_dout;
            RegLed:  if (r_write) w_led_d = r_wdata; else w_data_in_d = r_led;
            RegSw:   if (!r_write) w_data_in_d = {16'h0, sw_in};
            RegNone: if (!r_write) w_data_in_d = 32'h0;
          endcase
        end
      end
      StResp: begin
        w_state_d = StIdle;
      end
      StBad: begin
        // Unreachable encoding: fall back to reset values, keeping the LEDs.
        w_state_d    = StIdle;
        w_data_in_d  = 32'h0;
        w_ram_addr_d = '0;
        w_ram_din_d  = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_region   <= RegRam;
      r_cnt      <= 4'd0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_wdata    <= 32'h0;
      r_data_in  <= 32'h0;
      r_ready    <= 1'b0;
      r_bus_err  <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= 32'h0;
      r_ram_we   <= 1'b0;
      r_led      <= 32'h0;
    end else begin
      r_state    <= w_state_d;
      r_region   <= w_region_d;
      r_cnt      <= w_cnt_d;
      r_write    <= w_write_d;
      r_err      <= w_err_d;
      r_wdata    <= w_wdata_d;
      r_data_in  <= w_data_in_d;
      r_ready    <= w_ready_d;
      r_bus_err  <= w_bus_err_d;
      r_ram_addr <= w_ram_addr_d;
      r_ram_din  <= w_ram_din_d;
      r_ram_we   <= w_ram_we_d;
      r_led      <= w_led_d;
    end
  end

  assign data_in   = r_data_in;
  assign mio_ready = r_ready;
  assign bus_err   = r_bus_err;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign ram_we    = r_ram_we;
  assign led_out   = r_led;
  assign state_out = r_state;

endmodule
